simd_processing_element: RTL and testbench

- Parametrised next-generation systolic PE for the MoNDE array.
- Passes west/north operands east/south with a registered valid.
- Multiplies signed operands in 1, 2 or 4 SIMD lanes and accumulates per lane through a 2-stage pipeline (multiply, accumulate).
- Emits per-lane accumulated results on a first/last-framed handshake.

---
 rtl/simd_processing_element_if.sv | 31 +++
 rtl/simd_processing_element.sv | 164 ++++++++++++++++
 tb/tb_simd_processing_element.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_processing_element_if.sv
// Operand/result bundle for the MoNDE systolic PE.
// The slave modport is the PE's view; master is the driver/observer view.
interface simd_processing_element_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 40
);
  logic [1:0]             SIMD_control;
  logic                   in_valid;
  logic                   in_first;
  logic                   in_last;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [WIDTH-1:0]       out_a;
  logic [WIDTH-1:0]       out_b;
  logic                   out_valid;
  logic                   out_first;
  logic                   out_last;
  logic [4*ACC_WIDTH-1:0] out_c;
  logic                   out_c_valid;
  logic                   ovf;

  modport slave (
    input  SIMD_control, in_valid, in_first, in_last, in_a, in_b,
    output out_a, out_b, out_valid, out_first, out_last, out_c, out_c_valid, ovf
  );

  modport master (
    output SIMD_control, in_valid, in_first, in_last, in_a, in_b,
    input  out_a, out_b, out_valid, out_first, out_last, out_c, out_c_valid, ovf
  );
endinterface

// File: rtl/simd_processing_element.sv
// Systolic PE: registered west/north pass-through plus 1/2/4-lane signed MAC (multiply, accumulate).
// Define PE_SATURATE_EN for saturating per-lane accumulation with a sticky per-frame ovf flag.
module simd_processing_element #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  simd_processing_element_if.slave pe
);
  typedef enum logic [1:0] {
    MODE_X1  = 2'b00,
    MODE_X2  = 2'b01,
    MODE_X4  = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  localparam int unsigned W2 = WIDTH / 2;
  localparam int unsigned W4 = WIDTH / 4;
  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0]            out_a_q, out_b_q;
  logic                        out_valid_q, out_first_q, out_last_q;
  mode_e                       mode_q, beat_mode;
  logic                        s1_valid_q, s1_first_q, s1_last_q;
  mode_e                       s1_mode_q;
  logic signed [ACC_WIDTH-1:0] prod_d [4];
  logic signed [ACC_WIDTH-1:0] s1_prod_q [4];
  logic signed [ACC_WIDTH-1:0] acc_d [4];
  logic signed [ACC_WIDTH-1:0] acc_q [4];
  logic [4*ACC_WIDTH-1:0]      out_c_d, out_c_q;
  logic                        out_c_valid_d, out_c_valid_q;

  // Narrow lanes are sign-extended to WIDTH first, so one full-width multiplier form serves every mode.
  function automatic logic signed [ACC_WIDTH-1:0] lane_mul(logic signed [WIDTH-1:0] a,
                                                           logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return ACC_WIDTH'(p);
  endfunction

  function automatic int unsigned lane_count(mode_e m);
    unique case (m)
      MODE_X1: return 1;
      MODE_X2: return 2;
      default: return 4;
    endcase
  endfunction

  assign beat_mode = (pe.in_valid && pe.in_first) ? mode_e'(pe.SIMD_control) : mode_q;

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      prod_d[k] = '0;
      unique case (beat_mode)
        MODE_X1: if (k == 0) prod_d[k] = lane_mul(pe.in_a, pe.in_b);
        MODE_X2: if (k < 2)  prod_d[k] = lane_mul(WIDTH'($signed(pe.in_a[(k % 2)*W2 +: W2])),
                                                  WIDTH'($signed(pe.in_b[(k % 2)*W2 +: W2])));
        MODE_X4: prod_d[k] = lane_mul(WIDTH'($signed(pe.in_a[k*W4 +: W4])),
                                      WIDTH'($signed(pe.in_b[k*W4 +: W4])));
        default: ;
      endcase
    end
  end

`ifdef PE_SATURATE_EN
  logic                ovf_d, ovf_q;
  logic [ACC_WIDTH:0]  sum;
`endif

  always_comb begin
    acc_d         = acc_q;
    out_c_d       = out_c_q;
    out_c_valid_d = 1'b0;
`ifdef PE_SATURATE_EN
    ovf_d         = ovf_q;
    sum           = '0;
`endif
    if (s1_valid_q && s1_mode_q != MODE_BYP) begin
`ifdef PE_SATURATE_EN
      if (s1_first_q) ovf_d = 1'b0;
`endif
      for (int unsigned k = 0; k < 4; k++) begin
        if (k >= lane_count(s1_mode_q)) begin
          acc_d[k] = '0;
        end else if (s1_first_q) begin
          acc_d[k] = s1_prod_q[k];
        end else begin
`ifdef PE_SATURATE_EN
          // One guard bit: top two sum bits disagree exactly when the lane overflowed.
          sum = {acc_q[k][ACC_WIDTH-1], acc_q[k]} + {s1_prod_q[k][ACC_WIDTH-1], s1_prod_q[k]};
          if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            acc_d[k] = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            ovf_d    = 1'b1;
          end else begin
            acc_d[k] = sum[ACC_WIDTH-1:0];
          end
`else
          acc_d[k] = acc_q[k] + s1_prod_q[k];
`endif
        end
      end
      if (s1_last_q) begin
        for (int unsigned k = 0; k < 4; k++) out_c_d[k*ACC_WIDTH +: ACC_WIDTH] = acc_d[k];
        out_c_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      mode_q        <= MODE_X1;
      s1_valid_q    <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_mode_q     <= MODE_X1;
      s1_prod_q     <= '{default: '0};
      acc_q         <= '{default: '0};
      out_c_q       <= '0;
      out_c_valid_q <= 1'b0;
`ifdef PE_SATURATE_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      out_valid_q   <= pe.in_valid;
      out_first_q   <= pe.in_valid & pe.in_first;
      out_last_q    <= pe.in_valid & pe.in_last;
      s1_valid_q    <= pe.in_valid;
      if (pe.in_valid) begin
        out_a_q    <= pe.in_a;
        out_b_q    <= pe.in_b;
        mode_q     <= beat_mode;
        s1_first_q <= pe.in_first;
        s1_last_q  <= pe.in_last;
        s1_mode_q  <= beat_mode;
        s1_prod_q  <= prod_d;
      end
      acc_q         <= acc_d;
      out_c_q       <= out_c_d;
      out_c_valid_q <= out_c_valid_d;
`ifdef PE_SATURATE_EN
      ovf_q         <= ovf_d;
`endif
    end
  end

  assign pe.out_a       = out_a_q;
  assign pe.out_b       = out_b_q;
  assign pe.out_valid   = out_valid_q;
  assign pe.out_first   = out_first_q;
  assign pe.out_last    = out_last_q;
  assign pe.out_c       = out_c_q;
  assign pe.out_c_valid = out_c_valid_q;
`ifdef PE_SATURATE_EN
  assign pe.ovf         = ovf_q;
`else
  assign pe.ovf         = 1'b0;
`endif
endmodule

// File: tb/tb_simd_processing_element.sv
// Scoreboard bench for simd_processing_element: an untimed arithmetic model predicts
// pass-through and published lane results; a monitor compares them as the DUT presents them.
module tb_simd_processing_element;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned CW        = 4 * ACC_WIDTH;
  localparam longint      ACC_MAX   = (longint'(1) << (ACC_WIDTH - 1)) - 1;
  localparam longint      ACC_MIN   = -(longint'(1) << (ACC_WIDTH - 1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simd_processing_element_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  simd_processing_element #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .pe    (bus)
  );

  typedef struct {
    logic             rst;
    logic             v, f, l;
    logic [WIDTH-1:0] a, b;
  } pt_t;

  typedef struct {
    int unsigned cyc;
    logic [CW-1:0] c;
    logic          ovf;
  } res_t;

  pt_t  pt_q[$];
  res_t res_q[$];

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: the frame is applied to it instantly, without any pipeline.
  int unsigned      m_mode = 0;
  longint           m_acc [4] = '{default: 0};
  logic             m_ovf = 1'b0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic [CW-1:0]    m_c = '0;

  function automatic longint slice_val(logic [WIDTH-1:0] x, int unsigned k, int unsigned len);
    longint v;
    v = (longint'(x) >> (k * len)) & ((longint'(1) << len) - 1);
    if (v >= (longint'(1) << (len - 1))) v = v - (longint'(1) << len);
    return v;
  endfunction

  function automatic longint wrap_acc(longint s);
    longint m;
    m = longint'(1) << ACC_WIDTH;
    s = s % m;
    if (s > ACC_MAX) s = s - m;
    else if (s < ACC_MIN) s = s + m;
    return s;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_beat(input logic v, input logic f, input logic l, input logic [1:0] m,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned n, len;
    longint p, s, t;
    res_t r;
    if (!v) return;
    m_a = a;
    m_b = b;
    if (f) m_mode = int'(m);
    if (m_mode == 3) return;
    n   = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 4;
    len = WIDTH / n;
    if (f) m_ovf = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k >= n) begin
        m_acc[k] = 0;
      end else begin
        p = slice_val(a, k, len) * slice_val(b, k, len);
        if (f) begin
          m_acc[k] = p;
        end else begin
          s = m_acc[k] + p;
`ifdef PE_SATURATE_EN
          if (s > ACC_MAX) begin s = ACC_MAX; m_ovf = 1'b1; end
          else if (s < ACC_MIN) begin s = ACC_MIN; m_ovf = 1'b1; end
`else
          s = wrap_acc(s);
`endif
          m_acc[k] = s;
        end
      end
    end
    if (l) begin
      for (int unsigned k = 0; k < 4; k++) begin
        t = m_acc[k];
        m_c[k*ACC_WIDTH +: ACC_WIDTH] = t[ACC_WIDTH-1:0];
      end
      r.cyc = cyc + 2;
      r.c   = m_c;
      r.ovf = m_ovf;
      res_q.push_back(r);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic f, input logic l,
                       input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    pt_t e;
    @(negedge clk);
    reset            = r;
    bus.in_valid     = v;
    bus.in_first     = f;
    bus.in_last      = l;
    bus.SIMD_control = m;
    bus.in_a         = a;
    bus.in_b         = b;
    if (r) begin
      m_mode = 0;
      m_acc  = '{default: 0};
      m_ovf  = 1'b0;
      m_a    = '0;
      m_b    = '0;
      m_c    = '0;
      // A result due on the reset edge itself never appears.
      while (res_q.size() > 0 && res_q[$].cyc >= cyc + 1) void'(res_q.pop_back());
      e = '{rst: 1'b1, v: 1'b0, f: 1'b0, l: 1'b0, a: '0, b: '0};
    end else begin
      model_beat(v, f, l, m, a, b);
      e = '{rst: 1'b0, v: v, f: v & f, l: v & l, a: m_a, b: m_b};
    end
    pt_q.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask

  // Monitor: one pass-through expectation per driven cycle; results matched by due cycle.
  initial begin
    pt_t  e;
    res_t r;
    logic due;
    wait (pt_q.size() > 0);
    forever begin
      @(posedge clk);
      #1;
      if (pt_q.size() > 0) begin
        e = pt_q.pop_front();
        chk("passthru", CW'({bus.out_valid, bus.out_first, bus.out_last, bus.out_a, bus.out_b}),
            CW'({e.v, e.f, e.l, e.a, e.b}));
        if (e.rst) chk("reset_state", CW'({bus.out_c, bus.out_c_valid, bus.ovf}), '0);
      end
      due = (res_q.size() > 0 && res_q[0].cyc == cyc);
      if (!e.rst) chk("out_c_valid", CW'(bus.out_c_valid), CW'(due));
      if (due) begin
        r = res_q.pop_front();
        if (bus.out_c_valid) begin
          chk("out_c", bus.out_c, r.c);
          chk("ovf", CW'(bus.ovf), CW'(r.ovf));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_first     = 1'b0;
    bus.in_last      = 1'b0;
    bus.SIMD_control = 2'b00;
    bus.in_a         = '0;
    bus.in_b         = '0;

    // Reset overrides a valid beat
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'hFFFF, 16'hFFFF);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'hFFFF, 16'hFFFF);
    idle(3);

    // Beat with no prior first: mode 00 onto zeroed accumulators, SIMD_control ignored
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 16'd2, 16'd3);
    idle(2);

    // Mode 00 three-beat frame -> 9
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'd3, 16'd4);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'hFFFE, 16'd5);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'd7, 16'd1);
    // Back-to-back: mode 01 single beat immediately after last
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 16'h0203, 16'h04FF);
    // Mode 10 single beat
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 16'h1234, 16'h1111);
    idle(1);
    // Bypass frame: out_c holds, operands still flow
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 16'h5555, 16'hAAAA);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0102, 16'h0304);
    // first/last without valid are ignored
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'h7777, 16'h8888);
    idle(3);

    // Overflow region: 3 x 0x7FFF^2 in a 32-bit accumulator
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h7FFF, 16'h7FFF);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 16'h7FFF, 16'h7FFF);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'h7FFF, 16'h7FFF);
    idle(1);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'd1, 16'd1);
    idle(2);

    // Reset mid-frame discards the first beat
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'd5, 16'd5);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 16'd3, 16'd3);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            16'($urandom),
            16'($urandom));
    end
    idle(4);

    chk("pending_results", CW'(res_q.size()), '0);
    chk("out_c_hold", bus.out_c, m_c);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
